// File: rtl/jh_pkg.sv
// Shared constants, FSM encoding and bin tag layout for the joint histogram reader.
// Used by joint_histogram_reader (JH_READER_CHECKSUM_EN enables its checksum option).
package jh_pkg;

    localparam int JH_NUM_BINS  = 200;
    localparam int JH_CI_STRIDE = 100;
    localparam int JH_NI_STRIDE = 10;
    localparam int JH_BIN_W     = 16;
    localparam int JH_IDX_W     = 8;

    localparam logic [3:0] JH_DIGIT_MAX = 4'(JH_NI_STRIDE - 1);
    localparam logic [3:0] JH_NI_MAX    = 4'((JH_CI_STRIDE / JH_NI_STRIDE) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } jh_state_t;

    typedef struct packed {
        logic [JH_IDX_W-1:0] index;
        logic                ci;
        logic [3:0]          ni;
        logic [3:0]          rd;
    } jh_tag_t;

    localparam jh_tag_t JH_TAG_ZERO = jh_tag_t'(17'd0);

    // Cascaded digit counters: rd wraps into ni, ni wraps into ci; no division needed.
    function automatic jh_tag_t jh_next_tag(input jh_tag_t tag);
        jh_tag_t nxt;
        nxt       = tag;
        nxt.index = tag.index + 8'd1;
        if (tag.rd == JH_DIGIT_MAX) begin
            nxt.rd = 4'd0;
            if (tag.ni == JH_NI_MAX) begin
                nxt.ni = 4'd0;
                nxt.ci = tag.ci + 1'b1;
            end else begin
                nxt.ni = tag.ni + 4'd1;
            end
        end else begin
            nxt.rd = tag.rd + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/joint_histogram_reader_if.sv
// Downstream valid/ready stream carrying one tagged histogram bin per beat.
interface joint_histogram_reader_if
    import jh_pkg::*;
#(
    parameter int BIN_W = JH_BIN_W
);
    logic                m_valid_o;
    logic                m_ready_i;
    logic [BIN_W-1:0]    m_data_o;
    logic [JH_IDX_W-1:0] m_index_o;
    logic                m_ci_o;
    logic [3:0]          m_ni_o;
    logic [3:0]          m_rd_o;
    logic                m_last_o;

    modport master (
        output m_valid_o, m_data_o, m_index_o, m_ci_o, m_ni_o, m_rd_o, m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o, m_data_o, m_index_o, m_ci_o, m_ni_o, m_rd_o, m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/jh_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; head entry is always visible on head_data.
module jh_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push && (!full_s || pop_ok_s);
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; clr empties the queue without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clr) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/joint_histogram_reader.sv
// Drains the joint histogram store into a tagged valid/ready stream.
// Defining JH_READER_CHECKSUM_EN adds a per-frame bin total and mismatch flag.
module joint_histogram_reader
    import jh_pkg::*;
#(
    parameter int NUM_BINS   = JH_NUM_BINS,
    parameter int BIN_W      = JH_BIN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef JH_READER_CHECKSUM_EN
    input  logic [23:0]      expected_total_i,
    output logic [23:0]      total_o,
    output logic             sum_mismatch_o,
`endif
    input  logic             start_i,
    output logic             read_en_o,
    input  logic [BIN_W-1:0] bin_i,
    input  logic             done_read_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    joint_histogram_reader_if.master m
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TAG_W   = $bits(jh_tag_t);
    localparam int ENTRY_W = BIN_W + TAG_W;
    localparam logic [JH_IDX_W-1:0] LAST_IDX = JH_IDX_W'(NUM_BINS - 1);

    jh_state_t           state_r;
    jh_state_t           state_s;
    logic                read_en_r;
    logic                read_en_s;
    logic                rd_pending_r;
    logic [JH_IDX_W-1:0] issued_r;
    logic [JH_IDX_W-1:0] issued_s;
    jh_tag_t             tag_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                start_s;
    logic                pop_s;
    logic [CNT_W-1:0]    count_s;
    logic [CNT_W-1:0]    count_next_s;
    logic [ENTRY_W-1:0]  head_s;
    jh_tag_t             head_tag_s;

    assign start_s    = (state_r == ST_IDLE) && start_i;
    assign pop_s      = m.m_valid_o && m.m_ready_i;
    assign head_tag_s = jh_tag_t'(head_s[TAG_W-1:0]);

    jh_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_s),
        .push      (rd_pending_r),
        .push_data ({bin_i, tag_r}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    assign m.m_valid_o = (count_s != {CNT_W{1'b0}});
    assign m.m_data_o  = head_s[ENTRY_W-1:TAG_W];
    assign m.m_index_o = head_tag_s.index;
    assign m.m_ci_o    = head_tag_s.ci;
    assign m.m_ni_o    = head_tag_s.ni;
    assign m.m_rd_o    = head_tag_s.rd;
    assign m.m_last_o  = (head_tag_s.index == LAST_IDX);

    assign read_en_o = read_en_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign error_o   = error_r;

    // Next-state logic for the drain sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_s = ST_READ;
                else         state_s = ST_IDLE;
            end
            ST_READ: begin
                if (read_en_r && (issued_r == LAST_IDX)) state_s = ST_DRAIN;
                else                                     state_s = ST_READ;
            end
            ST_DRAIN: begin
                if (pop_s && m.m_last_o && (count_s == CNT_W'(1))) state_s = ST_DONE;
                else                                                 state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next request decision: next-cycle occupancy plus the request now in flight must leave room.
    always_comb begin
        count_next_s = count_s;
        issued_s     = issued_r;
        if (start_s) begin
            count_next_s = {CNT_W{1'b0}};
            issued_s     = {JH_IDX_W{1'b0}};
        end else begin
            count_next_s = count_s + CNT_W'(rd_pending_r) - CNT_W'(pop_s);
            issued_s     = issued_r + JH_IDX_W'(read_en_r);
        end
        read_en_s = (state_s == ST_READ) &&
                    (int'(issued_s) < NUM_BINS) &&
                    ((int'(count_next_s) + int'(read_en_r)) < FIFO_DEPTH);
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            read_en_r    <= 1'b0;
            rd_pending_r <= 1'b0;
            issued_r     <= {JH_IDX_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            read_en_r    <= read_en_s;
            rd_pending_r <= read_en_r;
            issued_r     <= issued_s;
            busy_r       <= (state_s == ST_READ) || (state_s == ST_DRAIN);
            done_r       <= (state_s == ST_DONE);
        end
    end

    // Tag counters and sticky protocol error, both evaluated on capture cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r   <= JH_TAG_ZERO;
            error_r <= 1'b0;
        end else if (start_s) begin
            tag_r   <= JH_TAG_ZERO;
            error_r <= 1'b0;
        end else if (rd_pending_r) begin
            tag_r <= jh_next_tag(tag_r);
            if (done_read_i != (tag_r.index == LAST_IDX)) begin
                error_r <= 1'b1;
            end
        end
    end

`ifdef JH_READER_CHECKSUM_EN
    logic [23:0] total_r;
    logic        sum_mismatch_r;

    assign total_o        = total_r;
    assign sum_mismatch_o = sum_mismatch_r;

    // Frame bin total; the comparison is latched on entry to DONE and held until restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_r        <= 24'd0;
            sum_mismatch_r <= 1'b0;
        end else if (start_s) begin
            total_r        <= 24'd0;
            sum_mismatch_r <= 1'b0;
        end else begin
            if (rd_pending_r) begin
                total_r <= total_r + 24'(bin_i);
            end
            if (state_s == ST_DONE) begin
                sum_mismatch_r <= (total_r != expected_total_i);
            end
        end
    end
`endif

endmodule
